bnn_maxpool_stage: RTL and testbench
====================================

// Module: bnn_maxpool_stage
// PURPOSE
//   Downstream of the BNN row sequencer: taps the binarized feature-map write stream.
//   Input is one 1-bit pixel per accepted cycle, 28x28, raster order.
//   Performs 2x2 binary max-pool (logical OR); 14x14 result goes to a pool memory write port.
//   Keeps a per-frame count of set pooled pixels and flags frame completion.
// PARAMETERS
//   IMG_W   28  input feature-map width in pixels (even)
//   IMG_H   28  input feature-map height in pixels (even)
//   ADDR_W  5   width of input row/col address buses
//   CNT_W   8   width of ones_count; must hold (IMG_W/2)*(IMG_H/2)
// PORTS
//   clk            in   1         rising-edge clock
//   rst            in   1         asynchronous, active-high reset
//   in_valid       in   1         pixel strobe: the output-memory enable/write strobe
//   in_row         in   ADDR_W    feature-map row of in_bit
//   in_col         in   ADDR_W    feature-map column of in_bit
//   in_bit         in   1         binarized activation
//   pool_wr_en     out  1         one-cycle write strobe to pool memory
//   pool_rowaddr   out  ADDR_W-1  pooled row (in_row>>1)
//   pool_coladdr   out  ADDR_W-1  pooled column (in_col>>1)
//   pool_data      out  1         pooled bit
//   frame_done     out  1         one-cycle pulse with the write of pooled (IMG_H/2-1, IMG_W/2-1)
//   ones_count     out  CNT_W     running count of pooled 1s in current frame
// BEHAVIOUR
//   - Reset (async, immediate): every output 0.
//     Clears linebuf (IMG_W/2 bits), pair_reg and ones_count.
//   - Sample accepted on a rising edge only when in_valid=1.
//     Ignored entirely (no state change) if in_col>=IMG_W or in_row>=IMG_H.
//   - Even column: pair_reg <= in_bit.
//   - Odd column: pair = pair_reg | in_bit; pair_reg <= 0 after use.
//   - Even row, odd col: linebuf[in_col>>1] <= pair. No pool write.
//   - Odd row, odd col: next edge registers the pool write:
//     * pool_wr_en=1
//     * pool_data = linebuf[in_col>>1] | pair
//     * pool_rowaddr = in_row>>1; pool_coladdr = in_col>>1
//     * linebuf[in_col>>1] <= 0
//   - Latency: pool_wr_en high exactly 1 cycle after the odd-row/odd-col sample edge.
//     pool_wr_en is low in every other cycle.
//   - Addresses and pool_data hold their last value while pool_wr_en=0.
//   - ones_count updates in the same edge as each pool write:
//     * write to (0,0): ones_count <= pool_data (frame restart)
//     * otherwise: ones_count <= ones_count + pool_data
//     * no saturation needed; width rule guaranteed by CNT_W
//   - frame_done is asserted in the same cycle as the final-pixel pool_wr_en.
//     ones_count is then final for the frame; it holds until the next (0,0) write.
//   - Back-to-back frames: row wraps IMG_H-1 -> 0 with no idle cycle.
//     No bubble required; linebuf was already cleared by the odd-row consumption.
//   - Input gaps: any number of in_valid=0 cycles between samples are tolerated; state is held.
//   - Reset mid-frame: state is lost; there is no resynchronisation logic.
//     An odd-row sample after reset pools against a zeroed linebuf.
//   - Odd column with no preceding even column in the row: pair_reg=0 is used.
// TESTING
//   1. Stream half a frame, assert rst for 1 cycle -> all outputs 0 without a clock edge.
//      Next full frame pools correctly.
//   2. All-ones 28x28 frame, in_valid continuous:
//      -> 196 pool writes, all pool_data=1.
//      -> frame_done once, at write (13,13); ones_count=196.
//   3. Single 1 at (row 5, col 9), rest 0:
//      -> only write (2,4) has pool_data=1.
//      -> ones_count=1 at frame_done.
//   4. Checkerboard (bit = row^col): every pooled bit=1, ones_count=196.
//      Repeat with in_valid toggling every other cycle -> identical writes.
//   5. Sample with in_col=30, in_bit=1 mid-frame -> no pool write.
//      Pooled map and ones_count unchanged vs. the same frame without it.
//   6. All-ones frame immediately followed by all-zero frame:
//      -> first frame_done shows ones_count=196.
//      -> second frame_done shows ones_count=0.
//      -> no pool write dropped at the wrap.

Source files
------------

// File: rtl/bnn_maxpool_stage_if.sv
// Pixel-in / pooled-write-out bundle for the BNN max-pool stage.
// The producer (row sequencer tap) uses master; the pooling stage uses slave.
interface bnn_maxpool_stage_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [ADDR_W-1:0] in_row;
  logic [ADDR_W-1:0] in_col;
  logic              in_bit;
  logic              pool_wr_en;
  logic [ADDR_W-2:0] pool_rowaddr;
  logic [ADDR_W-2:0] pool_coladdr;
  logic              pool_data;
  logic              frame_done;
  logic [CNT_W-1:0]  ones_count;

  modport master (
    output in_valid, in_row, in_col, in_bit,
    input  pool_wr_en, pool_rowaddr, pool_coladdr, pool_data, frame_done, ones_count
  );

  modport slave (
    input  in_valid, in_row, in_col, in_bit,
    output pool_wr_en, pool_rowaddr, pool_coladdr, pool_data, frame_done, ones_count
  );
endinterface

// File: rtl/bnn_maxpool_stage.sv
// 2x2 binary max-pool (OR) over a raster 1-bit feature map, with a per-frame
// count of set pooled pixels and a frame-completion pulse.
module bnn_maxpool_stage #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bnn_maxpool_stage_if.slave   bus
);
  localparam int PW = IMG_W / 2;
  localparam int PH = IMG_H / 2;
  localparam int PA = ADDR_W - 1;

  logic [PW-1:0]    linebuf;
  logic             pair_reg;

  logic             in_range;
  logic             pair;
  logic             top;
  logic             pooled;
  logic [PA-1:0]    prow;
  logic [PA-1:0]    pcol;

  logic             wr_en_q;
  logic [PA-1:0]    rowaddr_q;
  logic [PA-1:0]    coladdr_q;
  logic             data_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    prow     = bus.in_row[ADDR_W-1:1];
    pcol     = bus.in_col[ADDR_W-1:1];
    in_range = bus.in_valid
               && (bus.in_row < ADDR_W'(IMG_H))
               && (bus.in_col < ADDR_W'(IMG_W));
    pair     = pair_reg | bus.in_bit;
    top      = 1'b0;
    // Guard the read so an out-of-range column never indexes past linebuf.
    if (in_range) top = linebuf[pcol];
    pooled   = top | pair;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      linebuf   <= '0;
      pair_reg  <= 1'b0;
      wr_en_q   <= 1'b0;
      rowaddr_q <= '0;
      coladdr_q <= '0;
      data_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (in_range) begin
        if (!bus.in_col[0]) begin
          pair_reg <= bus.in_bit;
        end else begin
          pair_reg <= 1'b0;
          if (!bus.in_row[0]) begin
            linebuf[pcol] <= pair;
          end else begin
            // Consuming the slot clears it, so the next frame needs no bubble.
            linebuf[pcol] <= 1'b0;
            wr_en_q       <= 1'b1;
            data_q        <= pooled;
            rowaddr_q     <= prow;
            coladdr_q     <= pcol;
            done_q        <= (prow == PA'(PH - 1)) && (pcol == PA'(PW - 1));
            if (prow == '0 && pcol == '0) cnt_q <= CNT_W'(pooled);
            else                          cnt_q <= cnt_q + CNT_W'(pooled);
          end
        end
      end
    end
  end

  assign bus.pool_wr_en   = wr_en_q;
  assign bus.pool_rowaddr = rowaddr_q;
  assign bus.pool_coladdr = coladdr_q;
  assign bus.pool_data    = data_q;
  assign bus.frame_done   = done_q;
  assign bus.ones_count   = cnt_q;
endmodule

// File: tb/tb_bnn_maxpool_stage.sv
// Randomized raster streams against a block-OR reference model of the pool stage.
module tb_bnn_maxpool_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;

  bnn_maxpool_stage_if #(.ADDR_W(5), .CNT_W(8)) bus ();

  bnn_maxpool_stage #(.IMG_W(28), .IMG_H(28), .ADDR_W(5), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int r;
    int c;
    int d;
    int fd;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   done_log[$];
  bit   img [28][28];
  bit   pmap [14][14];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   h_r = 0, h_c = 0, h_d = 0, h_cnt = 0;
  bit   checking = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Every cycle: either the model says a write is due now, or outputs must idle and hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && checking) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("missed_write_cycle", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("wr_en", int'(bus.pool_wr_en), 1);
        chk("wr_row", int'(bus.pool_rowaddr), e.r);
        chk("wr_col", int'(bus.pool_coladdr), e.c);
        chk("wr_data", int'(bus.pool_data), e.d);
        chk("wr_frame_done", int'(bus.frame_done), e.fd);
        chk("wr_ones_count", int'(bus.ones_count), e.cnt);
        h_r = e.r; h_c = e.c; h_d = e.d; h_cnt = e.cnt;
        if (bus.pool_wr_en) begin
          if (bus.pool_rowaddr == 0 && bus.pool_coladdr == 0)
            for (int i = 0; i < 14; i++) for (int j = 0; j < 14; j++) pmap[i][j] = 1'b0;
          pmap[bus.pool_rowaddr][bus.pool_coladdr] = bus.pool_data;
          if (bus.frame_done) done_log.push_back(int'(bus.ones_count));
        end
      end else begin
        chk("idle_wr_en", int'(bus.pool_wr_en), 0);
        chk("idle_frame_done", int'(bus.frame_done), 0);
        chk("hold_row", int'(bus.pool_rowaddr), h_r);
        chk("hold_col", int'(bus.pool_coladdr), h_c);
        chk("hold_data", int'(bus.pool_data), h_d);
        chk("hold_ones_count", int'(bus.ones_count), h_cnt);
      end
    end
  end

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'($urandom_range(0, 1));
    bus.in_row   = 5'($urandom_range(0, 31));
    bus.in_col   = 5'($urandom_range(0, 31));
    @(negedge clk);
  endtask

  task automatic inject(input int r, input int c);
    bus.in_valid = 1'b1;
    bus.in_row   = 5'(r);
    bus.in_col   = 5'(c);
    bus.in_bit   = 1'b1;
    @(negedge clk);
  endtask

  // gap: 0 continuous, 1 in_valid toggling, 2 random idle runs
  task automatic stream(input int r0, input int nr, input int gap, input bit oob);
    exp_t e;
    int   b;
    int   top;
    bit   first = 1'b1;
    for (int r = r0; r < r0 + nr; r++) begin
      for (int c = 0; c < 28; c++) begin
        if (gap == 1 && !first) idle_cycle();
        if (gap == 2) repeat ($urandom_range(0, 2)) idle_cycle();
        first = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_row   = 5'(r);
        bus.in_col   = 5'(c);
        bus.in_bit   = img[r][c];
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          // Top half of the block is only known if its even row was streamed here.
          top = (r == r0) ? 0 : int'(img[r-1][c-1] | img[r-1][c]);
          b = top | int'(img[r][c-1] | img[r][c]);
          if (r / 2 == 0 && c / 2 == 0) m_cnt = b;
          else m_cnt = (m_cnt + b) % 256;
          e.due = cyc + 1;
          e.r   = r / 2;
          e.c   = c / 2;
          e.d   = b;
          e.fd  = (r / 2 == 13 && c / 2 == 13) ? 1 : 0;
          e.cnt = m_cnt;
          q.push_back(e);
        end
        @(negedge clk);
        if (oob && r == 10 && c == 4) inject(10, 30);
        if (oob && r == 11 && c == 6) inject(29, 7);
      end
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_const(input bit v);
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = v;
  endtask

  task automatic fill_random();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 1'($urandom_range(0, 1));
  endtask

  function automatic int done_at(input int idx);
    return (idx < done_log.size()) ? done_log[idx] : -1;
  endfunction

  initial begin
    int base;
    int sum;
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    bus.in_col   = '0;
    bus.in_bit   = 1'b0;

    #12;
    chk("por_wr_en", int'(bus.pool_wr_en), 0);
    chk("por_row", int'(bus.pool_rowaddr), 0);
    chk("por_col", int'(bus.pool_coladdr), 0);
    chk("por_data", int'(bus.pool_data), 0);
    chk("por_frame_done", int'(bus.frame_done), 0);
    chk("por_ones_count", int'(bus.ones_count), 0);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Half frame ending on an even row leaves linebuf full of ones.
    fill_const(1'b1);
    stream(0, 15, 0, 1'b0);
    drain();
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_en", int'(bus.pool_wr_en), 0);
    chk("arst_row", int'(bus.pool_rowaddr), 0);
    chk("arst_col", int'(bus.pool_coladdr), 0);
    chk("arst_data", int'(bus.pool_data), 0);
    chk("arst_frame_done", int'(bus.frame_done), 0);
    chk("arst_ones_count", int'(bus.ones_count), 0);
    q.delete();
    h_r = 0; h_c = 0; h_d = 0; h_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Odd row right after reset must pool against a cleared linebuf.
    fill_const(1'b0);
    stream(1, 1, 0, 1'b0);
    drain();
    base = done_log.size();
    fill_random();
    stream(0, 28, 2, 1'b0);
    drain();
    chk("t1_done_pulses", done_log.size() - base, 1);

    // All-ones frame.
    base = done_log.size();
    fill_const(1'b1);
    stream(0, 28, 0, 1'b0);
    drain();
    chk("t2_done_pulses", done_log.size() - base, 1);
    chk("t2_ones_count", done_at(base), 196);

    // Single set pixel at (5,9), then the same frame with out-of-range samples mixed in.
    for (int pass = 0; pass < 2; pass++) begin
      base = done_log.size();
      fill_const(1'b0);
      img[5][9] = 1'b1;
      stream(0, 28, pass * 2, pass == 1);
      drain();
      sum = 0;
      for (int i = 0; i < 14; i++) for (int j = 0; j < 14; j++) sum += int'(pmap[i][j]);
      chk(pass == 0 ? "t3_ones_count" : "t5_ones_count", done_at(base), 1);
      chk(pass == 0 ? "t3_pmap_2_4" : "t5_pmap_2_4", int'(pmap[2][4]), 1);
      chk(pass == 0 ? "t3_pmap_sum" : "t5_pmap_sum", sum, 1);
    end

    // Checkerboard, continuous then with in_valid toggling.
    for (int pass = 0; pass < 2; pass++) begin
      base = done_log.size();
      for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r][c] = 1'((r ^ c) & 1);
      stream(0, 28, pass, 1'b0);
      drain();
      chk(pass == 0 ? "t4_ones_count" : "t4_toggle_ones_count", done_at(base), 196);
    end

    // All-ones followed by all-zeros with no idle cycle at the wrap.
    base = done_log.size();
    fill_const(1'b1);
    stream(0, 28, 0, 1'b0);
    fill_const(1'b0);
    stream(0, 28, 0, 1'b0);
    drain();
    chk("t6_done_pulses", done_log.size() - base, 2);
    chk("t6_first_count", done_at(base), 196);
    chk("t6_second_count", done_at(base + 1), 0);

    // Random frames, back-to-back and with random gaps.
    for (int k = 0; k < 4; k++) begin
      fill_random();
      stream(0, 28, (k % 2) * 2, 1'b0);
    end
    drain();

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
